exp_op_sequencer: RTL and testbench
===================================

# exp_op_sequencer

Sequencing controller for the shared exponent add/subtract datapath of the FPU. It accepts one exponent job at a time: an alignment difference, a plain sum, or the two-pass bias-corrected exponent for multiply or divide. It drives the datapath's operands, operation select and load strobe, then evaluates and saturates the final exponent and raises overflow/underflow. It sits between the FPU top-level control FSM and the exponent datapath, which is instantiated at width EW+2.

## Interface
- EW, 8: exponent width; BIAS is fixed at 2^(EW-1)-1 (127 for EW=8).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- start_i  in  1  job request; sampled only in IDLE.
- op_i  in  2  job select: 00 SUB (A-B), 01 MUL (A+B-BIAS), 10 DIV (A-B+BIAS), 11 ADD (A+B).
- exp_a_i  in  EW  operand A, unsigned biased exponent; latched with start.
- exp_b_i  in  EW  operand B, unsigned biased exponent; latched with start.
- dp_op_o  out  1  datapath operation: 0 add, 1 subtract.
- dp_a_o  out  EW+2  datapath operand A.
- dp_b_o  out  EW+2  datapath operand B.
- dp_load_o  out  1  datapath result-register load.
- dp_result_i  in  EW+2  registered datapath result; two's complement; valid the cycle after dp_load_o.
- busy_o  out  1  high while state is not IDLE.
- done_o  out  1  one-cycle pulse; result and flags are valid.
- result_o  out  EW  final exponent, saturated; held until the next done.
- overflow_o  out  1  final exponent is at least 2^EW-1; held until the next done.
- underflow_o  out  1  final exponent is at most 0; held until the next done.

## Operation
- FSM states: IDLE, PASS1, PASS2, EVAL.
  - IDLE -> PASS1 when start_i=1; latch op_i, exp_a_i and exp_b_i.
  - PASS1 -> PASS2 for MUL/DIV; PASS1 -> EVAL for SUB/ADD.
  - PASS2 -> EVAL.
  - EVAL -> IDLE.
- PASS1:
  - dp_a_o = zero-extended A; dp_b_o = zero-extended B.
  - dp_op_o = 1 for SUB/DIV, 0 for ADD/MUL.
  - dp_load_o = 1.
- PASS2:
  - dp_a_o = dp_result_i; dp_b_o = BIAS zero-extended.
  - dp_op_o = 1 for MUL, 0 for DIV.
  - dp_load_o = 1.
- dp_load_o = 0 and dp_a_o/dp_b_o/dp_op_o = 0 in IDLE and EVAL. These outputs are decoded combinationally from state and the latched operands.
- EVAL: interpret dp_result_i as signed EW+2 bits, call it R.
  - R ≥ 2^EW-1: overflow_o=1, result_o=all ones.
  - R ≤ 0: underflow_o=1, result_o=0.
  - Otherwise: result_o=R[EW-1:0], both flags 0.
  - These registers update on the EVAL->IDLE edge; done_o is registered high for exactly that following cycle.
- The EW+2 width guarantees no intermediate wrap: MUL maximum 2·(2^EW-1); DIV minimum -(2^EW-1).
- Operand value 0 is not special-cased; zero/denormal handling is upstream.

## Timing
- Reset values: all outputs 0, state IDLE, latched operands 0.
- Latency, counting edge 0 as the edge where start is sampled:
  - done_o is high in the cycle after edge 2 for SUB/ADD.
  - done_o is high in the cycle after edge 3 for MUL/DIV.
- start_i while busy_o=1 is ignored; no queuing.
- start_i is accepted in the same cycle done_o is high, because state is IDLE. Back-to-back throughput: one job per 3 cycles (single-pass) or 4 cycles (two-pass).
- Latched operands are immune to exp_a_i/exp_b_i changes after acceptance.
- Reset asserted mid-job: immediate return to IDLE, all outputs 0, no done_o pulse. The next start after release runs normally.
- op_i/exp_*_i are don't-care while not sampled.

## Structure
- Package exp_seq_pkg:
  - op encodings SUB/MUL/DIV/ADD;
  - state encoding;
  - bias function of EW;
  - the EW+2 datapath-width localparam.
- Sub-module exp_seq_eval: combinational signed compare plus saturation of R into result/overflow/underflow. Reused by the FPU's normalisation path.
- Exponent datapath stays external; the controller owns no adder.

## Test plan
- MUL A=130, B=130 -> result_o=133, flags 0, done_o 4 cycles after start edge; dp_load_o high exactly 2 cycles.
- MUL A=200, B=200 (R=273) -> overflow_o=1, result_o=0xFF. MUL A=10, B=20 (R=-97) -> underflow_o=1, result_o=0x00.
- DIV A=10, B=200 (R=-63) -> underflow_o=1, result_o=0. DIV A=200, B=10 (R=317) -> overflow_o=1.
- SUB A=100, B=100 -> underflow_o=1, result_o=0; ADD A=100, B=27 -> result_o=127, done_o 3 cycles after start.
- start_i held high with changing operands across four two-pass jobs:
  - done_o every 4 cycles;
  - each result matches the operands present at its acceptance edge;
  - mid-job operand changes have no effect.
- rst low during PASS2 -> outputs and busy_o 0 asynchronously, no done_o. After release, ADD A=1, B=1 -> result_o=2.

Source files
------------

// File: rtl/exp_seq_pkg.sv
// exp_seq_pkg
// Shared definitions for the exponent operation sequencer:
//   - job encodings driven by the FPU control FSM on op_i
//   - sequencer state encoding
//   - exponent bias as a function of the exponent width
//   - default exponent width and the widened datapath width derived from it
package exp_seq_pkg;

  localparam int unsigned EXP_W = 8;
  // Two extra bits keep the two-pass MUL/DIV intermediates from wrapping.
  localparam int unsigned DP_W  = EXP_W + 2;

  typedef enum logic [1:0] {
    OP_SUB = 2'b00,   // A - B
    OP_MUL = 2'b01,   // A + B - BIAS
    OP_DIV = 2'b10,   // A - B + BIAS
    OP_ADD = 2'b11    // A + B
  } exp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS1,
    ST_PASS2,
    ST_EVAL
  } seq_state_e;

  function automatic int unsigned exp_bias(input int unsigned ew);
    return (32'd1 << (ew - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/exp_seq_eval.sv
// exp_seq_eval
// Combinational saturation of a signed widened exponent into an EW-bit
// exponent with overflow/underflow flags.
// Ports:
//   r          in   EW+2  signed two's complement exponent
//   result     out  EW    saturated exponent
//   overflow   out  1     r >= 2^EW-1 (result forced to all ones)
//   underflow  out  1     r <= 0 (result forced to zero)
module exp_seq_eval
  import exp_seq_pkg::*;
#(
  parameter int unsigned EW = EXP_W
) (
  input  logic [EW+1:0] r,
  output logic [EW-1:0] result,
  output logic          overflow,
  output logic          underflow
);

  localparam logic signed [EW+1:0] SAT_MAX = {2'b00, {EW{1'b1}}};
  localparam logic signed [EW+1:0] ZERO    = '0;

  logic signed [EW+1:0] r_s;
  assign r_s = r;

  // Both operands of each compare are signed so negative values order correctly.
  always_comb begin
    result    = r[EW-1:0];
    overflow  = 1'b0;
    underflow = 1'b0;
    if (r_s >= SAT_MAX) begin
      result   = '1;
      overflow = 1'b1;
    end else if (r_s <= ZERO) begin
      result    = '0;
      underflow = 1'b1;
    end
  end

endmodule

// File: rtl/exp_op_sequencer.sv
// exp_op_sequencer
// Sequences one exponent job at a time through the external shared
// add/subtract datapath (one or two passes), then saturates the result.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start_i             job request, sampled only while idle
//   op_i                job select (SUB/MUL/DIV/ADD)
//   exp_a_i, exp_b_i    biased exponent operands, latched with start
//   dp_op_o             datapath operation, 0 add / 1 subtract
//   dp_a_o, dp_b_o      datapath operands (EW+2 bits)
//   dp_load_o           datapath result-register load
//   dp_result_i         registered datapath result (signed, EW+2 bits)
//   busy_o              job in progress
//   done_o              one-cycle pulse when result/flags are updated
//   result_o            saturated final exponent, held until next done
//   overflow_o          final exponent >= 2^EW-1, held until next done
//   underflow_o         final exponent <= 0, held until next done
module exp_op_sequencer
  import exp_seq_pkg::*;
#(
  parameter int unsigned EW = EXP_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [EW-1:0] exp_a_i,
  input  logic [EW-1:0] exp_b_i,
  output logic          dp_op_o,
  output logic [EW+1:0] dp_a_o,
  output logic [EW+1:0] dp_b_o,
  output logic          dp_load_o,
  input  logic [EW+1:0] dp_result_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [EW-1:0] result_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam int unsigned DW      = EW + 2;
  localparam logic [DW-1:0] BIAS_DP = DW'(exp_bias(EW));

  seq_state_e    state, next_state;
  exp_op_e       op_q;
  logic [EW-1:0] a_q, b_q;

  logic [EW-1:0] eval_result;
  logic          eval_overflow, eval_underflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operands are captured only on acceptance, so input changes mid-job are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= OP_SUB;
      a_q  <= '0;
      b_q  <= '0;
    end else if (state == ST_IDLE && start_i) begin
      op_q <= exp_op_e'(op_i);
      a_q  <= exp_a_i;
      b_q  <= exp_b_i;
    end
  end

  // PASS1 forms A+/-B; PASS2 feeds the PASS1 result back and applies the bias.
  always_comb begin
    next_state = state;
    dp_op_o    = 1'b0;
    dp_a_o     = '0;
    dp_b_o     = '0;
    dp_load_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) next_state = ST_PASS1;
      end
      ST_PASS1: begin
        dp_a_o     = {2'b00, a_q};
        dp_b_o     = {2'b00, b_q};
        dp_op_o    = (op_q == OP_SUB) || (op_q == OP_DIV);
        dp_load_o  = 1'b1;
        next_state = ((op_q == OP_MUL) || (op_q == OP_DIV)) ? ST_PASS2 : ST_EVAL;
      end
      ST_PASS2: begin
        dp_a_o     = dp_result_i;
        dp_b_o     = BIAS_DP;
        dp_op_o    = (op_q == OP_MUL);
        dp_load_o  = 1'b1;
        next_state = ST_EVAL;
      end
      ST_EVAL: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign busy_o = (state != ST_IDLE);

  exp_seq_eval #(.EW(EW)) u_eval (
    .r         (dp_result_i),
    .result    (eval_result),
    .overflow  (eval_overflow),
    .underflow (eval_underflow)
  );

  // Result and flags are captured on the EVAL->IDLE edge and held until the next job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_o      <= 1'b0;
      result_o    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      done_o <= (state == ST_EVAL);
      if (state == ST_EVAL) begin
        result_o    <= eval_result;
        overflow_o  <= eval_overflow;
        underflow_o <= eval_underflow;
      end
    end
  end

endmodule

// File: tb/tb_exp_op_sequencer.sv
// tb_exp_op_sequencer
// Self-checking bench: directed jobs with timing/datapath checks, a
// randomized job stream against an arithmetic reference model, and
// asynchronous reset mid-job. Includes a behavioural model of the
// external exponent datapath register.
module tb_exp_op_sequencer;

  localparam logic [1:0] SUB = 2'b00;
  localparam logic [1:0] MUL = 2'b01;
  localparam logic [1:0] DIV = 2'b10;
  localparam logic [1:0] ADD = 2'b11;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       dp_op;
  logic [9:0] dp_a, dp_b;
  logic       dp_load;
  logic [9:0] dp_res;
  logic       busy, done;
  logic [7:0] result;
  logic       ovf, unf;

  int vectors     = 0;
  int miscompares = 0;

  exp_op_sequencer #(.EW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .op_i        (op),
    .exp_a_i     (a),
    .exp_b_i     (b),
    .dp_op_o     (dp_op),
    .dp_a_o      (dp_a),
    .dp_b_o      (dp_b),
    .dp_load_o   (dp_load),
    .dp_result_i (dp_res),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .overflow_o  (ovf),
    .underflow_o (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External datapath: registered add/subtract, result valid the cycle after load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dp_res <= '0;
    else if (dp_load) dp_res <= dp_op ? (dp_a - dp_b) : (dp_a + dp_b);
  end

  // Reference: {overflow, underflow, result} from plain integer arithmetic.
  function automatic logic [9:0] ref_eval(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int xi, yi, r;
    xi = x;
    yi = y;
    case (o)
      SUB:     r = xi - yi;
      MUL:     r = xi + yi - 127;
      DIV:     r = xi - yi + 127;
      default: r = xi + yi;
    endcase
    if (r >= 255)    return {2'b10, 8'hFF};
    else if (r <= 0) return {2'b01, 8'h00};
    else             return {2'b00, 8'(r)};
  endfunction

  function automatic bit is_two_pass(input logic [1:0] o);
    return (o == MUL) || (o == DIV);
  endfunction

  task automatic test_reset;
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, result, ovf, unf, dp_load, dp_op, dp_a, dp_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b res=%0d ovf=%0b unf=%0b load=%0b op=%0b a=%0d b=%0d expected all 0",
               busy, done, result, ovf, unf, dp_load, dp_op, dp_a, dp_b);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_job(input string name, input logic [1:0] jop, input logic [7:0] ja, input logic [7:0] jb);
    logic [9:0] ex;
    logic [9:0] p1;
    int lat, loads, done_at, pulses, p;
    ex      = ref_eval(jop, ja, jb);
    lat     = is_two_pass(jop) ? 3 : 2;
    p       = (jop == MUL) ? (int'(ja) + int'(jb)) : (int'(ja) - int'(jb));
    p1      = 10'(p);
    loads   = 0;
    done_at = -1;
    pulses  = 0;
    @(negedge clk);
    start = 1'b1;
    op    = jop;
    a     = ja;
    b     = jb;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = ~ja;
    b     = 8'($urandom);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (dp_load) begin
        loads++;
        vectors++;
        if (loads == 1) begin
          if (dp_a !== {2'b00, ja} || dp_b !== {2'b00, jb} || dp_op !== (jop == SUB || jop == DIV)) begin
            miscompares++;
            $display("FAIL %s pass1_dp: got a=%0d b=%0d op=%0b expected a=%0d b=%0d op=%0b",
                     name, dp_a, dp_b, dp_op, ja, jb, (jop == SUB || jop == DIV));
          end
        end else begin
          if (dp_a !== p1 || dp_b !== 10'd127 || dp_op !== (jop == MUL)) begin
            miscompares++;
            $display("FAIL %s pass2_dp: got a=%0d b=%0d op=%0b expected a=%0d b=127 op=%0b",
                     name, dp_a, dp_b, dp_op, p1, (jop == MUL));
          end
        end
      end
      if (done) begin
        pulses++;
        if (done_at < 0) begin
          done_at = n;
          vectors++;
          if ({ovf, unf, result} !== ex) begin
            miscompares++;
            $display("FAIL %s result: got ovf=%0b unf=%0b res=%0d expected ovf=%0b unf=%0b res=%0d",
                     name, ovf, unf, result, ex[9], ex[8], ex[7:0]);
          end
        end
      end
    end
    vectors++;
    if (done_at != lat || pulses != 1) begin
      miscompares++;
      $display("FAIL %s done_timing: got cycle=%0d pulses=%0d expected cycle=%0d pulses=1", name, done_at, pulses, lat);
    end
    vectors++;
    if (loads != (lat - 1)) begin
      miscompares++;
      $display("FAIL %s load_cycles: got %0d expected %0d", name, loads, lat - 1);
    end
    vectors++;
    if ({ovf, unf, result} !== ex || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s held: got ovf=%0b unf=%0b res=%0d busy=%0b expected ovf=%0b unf=%0b res=%0d busy=0",
               name, ovf, unf, result, busy, ex[9], ex[8], ex[7:0]);
    end
  endtask

  // Streams jobs; operands change every cycle, the model decides which edges accept.
  task automatic test_stream(input string name, input int cycles, input bit two_pass_only, input bit start_always);
    logic [9:0] exp_q[$];
    int due_q[$];
    int ready, busy_end, lat;
    bit exp_done, exp_busy;
    ready    = 0;
    busy_end = 0;
    for (int t = 0; t < cycles + 8; t++) begin
      if (t < cycles) start = start_always ? 1'b1 : ($urandom_range(0, 2) == 0);
      else            start = 1'b0;
      op = two_pass_only ? ($urandom_range(0, 1) ? MUL : DIV) : 2'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      @(posedge clk);
      if (start && t >= ready) begin
        lat = is_two_pass(op) ? 3 : 2;
        exp_q.push_back(ref_eval(op, a, b));
        due_q.push_back(t + lat);
        busy_end = t + lat;
        ready    = t + lat + 1;
      end
      @(negedge clk);
      exp_done = (due_q.size() > 0) && (due_q[0] == t);
      exp_busy = (t < busy_end);
      vectors++;
      if (done !== exp_done || busy !== exp_busy) begin
        miscompares++;
        $display("FAIL %s handshake t=%0d: got done=%0b busy=%0b expected done=%0b busy=%0b",
                 name, t, done, busy, exp_done, exp_busy);
      end
      if (exp_done) begin
        vectors++;
        if ({ovf, unf, result} !== exp_q[0]) begin
          miscompares++;
          $display("FAIL %s result t=%0d: got ovf=%0b unf=%0b res=%0d expected ovf=%0b unf=%0b res=%0d",
                   name, t, ovf, unf, result, exp_q[0][9], exp_q[0][8], exp_q[0][7:0]);
        end
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: got %0d jobs outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset_midjob;
    @(negedge clk);
    start = 1'b1;
    op    = MUL;
    a     = 8'd150;
    b     = 8'd140;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    vectors++;
    if (dp_load !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid pass2_active: got load=%0b busy=%0b expected 1 1", dp_load, busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy, done, result, ovf, unf, dp_load, dp_op, dp_a, dp_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid async: got busy=%0b done=%0b res=%0d ovf=%0b unf=%0b load=%0b a=%0d b=%0d expected all 0",
               busy, done, result, ovf, unf, dp_load, dp_a, dp_b);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid held: got done=%0b busy=%0b expected 0 0", done, busy);
      end
    end
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid no_done: got done=%0b expected 0", done);
      end
    end
    test_job("after_reset_add", ADD, 8'd1, 8'd1);
  endtask

  initial begin
    test_reset();
    test_job("mul_130_130", MUL, 8'd130, 8'd130);
    test_job("mul_ovf", MUL, 8'd200, 8'd200);
    test_job("mul_unf", MUL, 8'd10, 8'd20);
    test_job("div_unf", DIV, 8'd10, 8'd200);
    test_job("div_ovf", DIV, 8'd200, 8'd10);
    test_job("sub_zero", SUB, 8'd100, 8'd100);
    test_job("add_127", ADD, 8'd100, 8'd27);
    test_job("add_max", ADD, 8'd200, 8'd54);
    test_job("sub_one", SUB, 8'd5, 8'd4);
    test_stream("back_to_back", 16, 1'b1, 1'b1);
    test_stream("random_mix", 300, 1'b0, 1'b0);
    test_stream("random_held", 100, 1'b0, 1'b1);
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
